xadac_vrf_dispatch: RTL and testbench



---
 rtl/xadac_pkg.sv | 25 ++
 rtl/xadac_vrf.sv | 44 ++++
 rtl/xadac_vrf_dispatch.sv | 210 +++++++++++++++++++++
 tb/tb_xadac_vrf_dispatch.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xadac_pkg
// Description : Shared widths and types for the XADAC vector datapath.
// Revision    : 1.0 - vector register file dispatch types
// ============================================================================
package xadac_pkg;

    localparam int unsigned ElemWidth   = 8;
    localparam int unsigned SumWidth    = 32;

    // A vector register holds one SumWidth accumulator per ElemWidth lane of a SumWidth word.
    localparam int unsigned VectorWidth = (SumWidth / ElemWidth) * SumWidth;

    localparam int unsigned NrVregsDefault = 32;
    typedef logic [$clog2(NrVregsDefault)-1:0] vreg_idx_t;

    typedef enum logic [1:0] {
        DISP_IDLE  = 2'd0,
        DISP_CHECK = 2'd1,
        DISP_ISSUE = 2'd2
    } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/xadac_vrf.sv
`default_nettype none
// ============================================================================
// Module      : xadac_vrf
// Description : Vector register file, 3 async read ports, 2 prioritised write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module xadac_vrf #(
    parameter int unsigned  NrVregs     = 32,
    parameter int unsigned  VectorWidth = xadac_pkg::VectorWidth,
    localparam int unsigned VregIdxW    = $clog2(NrVregs)
) (
    input  logic                   clk_i,
    input  logic [VregIdxW-1:0]    raddr1_i,
    input  logic [VregIdxW-1:0]    raddr2_i,
    input  logic [VregIdxW-1:0]    raddr3_i,
    output logic [VectorWidth-1:0] rdata1_o,
    output logic [VectorWidth-1:0] rdata2_o,
    output logic [VectorWidth-1:0] rdata3_o,
    input  logic                   wa_valid_i,
    input  logic [VregIdxW-1:0]    wa_addr_i,
    input  logic [VectorWidth-1:0] wa_data_i,
    input  logic                   wb_valid_i,
    input  logic [VregIdxW-1:0]    wb_addr_i,
    input  logic [VectorWidth-1:0] wb_data_i
);

    logic [VectorWidth-1:0] mem_q [NrVregs];

    // Port A wins when both ports target the same register in one cycle.
    always_ff @(posedge clk_i) begin
        if (wa_valid_i) begin
            mem_q[wa_addr_i] <= wa_data_i;
        end
        if (wb_valid_i && !(wa_valid_i && (wa_addr_i == wb_addr_i))) begin
            mem_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
    assign rdata3_o = mem_q[raddr3_i];

endmodule
`default_nettype wire

// File: rtl/xadac_vrf_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : xadac_vrf_dispatch
// Description : Operand fetch, scoreboard and writeback ahead of XADAC units.
// Revision    : 1.0 - initial release
// ============================================================================
module xadac_vrf_dispatch #(
    parameter int unsigned  NrVregs     = 32,
    parameter int unsigned  VectorWidth = xadac_pkg::VectorWidth,
    parameter int unsigned  IdWidth     = 3,
    parameter int unsigned  ImmWidth    = 5,
    localparam int unsigned VregIdxW    = $clog2(NrVregs)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dec_valid_i,
    output logic                   dec_ready_o,
    input  logic [IdWidth-1:0]     dec_id_i,
    input  logic [VregIdxW-1:0]    dec_vs1_i,
    input  logic [VregIdxW-1:0]    dec_vs2_i,
    input  logic [VregIdxW-1:0]    dec_vs3_i,
    input  logic [VregIdxW-1:0]    dec_vd_i,
    input  logic [ImmWidth-1:0]    dec_imm_i,
    output logic                   ex_req_valid_o,
    input  logic                   ex_req_ready_i,
    output logic [IdWidth-1:0]     ex_req_id_o,
    output logic [VectorWidth-1:0] ex_req_vs1_o,
    output logic [VectorWidth-1:0] ex_req_vs2_o,
    output logic [VectorWidth-1:0] ex_req_vs3_o,
    output logic [ImmWidth-1:0]    ex_req_imm_o,
    input  logic                   ex_resp_valid_i,
    output logic                   ex_resp_ready_o,
    input  logic [IdWidth-1:0]     ex_resp_id_i,
    input  logic [VectorWidth-1:0] ex_resp_vd_i,
    input  logic                   wr_valid_i,
    input  logic [VregIdxW-1:0]    wr_addr_i,
    input  logic [VectorWidth-1:0] wr_data_i,
    output logic                   cmt_valid_o,
    output logic [IdWidth-1:0]     cmt_id_o
);

    import xadac_pkg::*;

    localparam int unsigned NR_IDS   = 2 ** IdWidth;
    localparam logic [1:0]  ST_IDLE  = DISP_IDLE;
    localparam logic [1:0]  ST_CHECK = DISP_CHECK;
    localparam logic [1:0]  ST_ISSUE = DISP_ISSUE;

    logic [1:0]             state_q, state_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [VregIdxW-1:0]    vs1_q, vs1_d;
    logic [VregIdxW-1:0]    vs2_q, vs2_d;
    logic [VregIdxW-1:0]    vs3_q, vs3_d;
    logic [VregIdxW-1:0]    vd_q, vd_d;
    logic [ImmWidth-1:0]    imm_q, imm_d;
    logic [VectorWidth-1:0] op1_q, op1_d;
    logic [VectorWidth-1:0] op2_q, op2_d;
    logic [VectorWidth-1:0] op3_q, op3_d;
    logic [NrVregs-1:0]     pending_q, pending_d;
    logic [NR_IDS-1:0]      inflight_q, inflight_d;
    logic [VregIdxW-1:0]    vd_tab_q [NR_IDS];
    logic                   cmt_valid_q;
    logic [IdWidth-1:0]     cmt_id_q;

    logic [VectorWidth-1:0] w_rd1, w_rd2, w_rd3;
    logic                   w_wr_hit;
    logic                   w_check_stall;
    logic                   w_check_go;
    logic                   w_resp_fire;
    logic                   w_resp_ok;
    logic [VregIdxW-1:0]    w_resp_vd;

    assign dec_ready_o     = (state_q == ST_IDLE) && !rst_i;
    assign ex_req_valid_o  = (state_q == ST_ISSUE) && !rst_i;
    assign ex_resp_ready_o = !wr_valid_i;

    assign ex_req_id_o  = id_q;
    assign ex_req_imm_o = imm_q;
    assign ex_req_vs1_o = op1_q;
    assign ex_req_vs2_o = op2_q;
    assign ex_req_vs3_o = op3_q;
    assign cmt_valid_o  = cmt_valid_q;
    assign cmt_id_o     = cmt_id_q;

    // A same-cycle load-unit write to any operand would race the read, so it stalls too.
    assign w_wr_hit = wr_valid_i && ((wr_addr_i == vs1_q) || (wr_addr_i == vs2_q) ||
                                     (wr_addr_i == vs3_q) || (wr_addr_i == vd_q));

    assign w_check_stall = pending_q[vs1_q] || pending_q[vs2_q] || pending_q[vs3_q] ||
                           pending_q[vd_q] || inflight_q[id_q] || w_wr_hit;
    assign w_check_go    = (state_q == ST_CHECK) && !w_check_stall;

    assign w_resp_fire = ex_resp_valid_i && ex_resp_ready_o;
    assign w_resp_ok   = w_resp_fire && inflight_q[ex_resp_id_i] && !rst_i;
    assign w_resp_vd   = vd_tab_q[ex_resp_id_i];

    xadac_vrf #(
        .NrVregs     (NrVregs),
        .VectorWidth (VectorWidth)
    ) u_vrf (
        .clk_i      (clk_i),
        .raddr1_i   (vs1_q),
        .raddr2_i   (vs2_q),
        .raddr3_i   (vs3_q),
        .rdata1_o   (w_rd1),
        .rdata2_o   (w_rd2),
        .rdata3_o   (w_rd3),
        .wa_valid_i (wr_valid_i),
        .wa_addr_i  (wr_addr_i),
        .wa_data_i  (wr_data_i),
        .wb_valid_i (w_resp_ok),
        .wb_addr_i  (w_resp_vd),
        .wb_data_i  (ex_resp_vd_i)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        vs3_d      = vs3_q;
        vd_d       = vd_q;
        imm_d      = imm_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        op3_d      = op3_q;
        pending_d  = pending_q;
        inflight_d = inflight_q;

        case (state_q)
            ST_IDLE: begin
                if (dec_valid_i) begin
                    id_d    = dec_id_i;
                    vs1_d   = dec_vs1_i;
                    vs2_d   = dec_vs2_i;
                    vs3_d   = dec_vs3_i;
                    vd_d    = dec_vd_i;
                    imm_d   = dec_imm_i;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_check_stall) begin
                    op1_d             = w_rd1;
                    op2_d             = w_rd2;
                    op3_d             = w_rd3;
                    pending_d[vd_q]   = 1'b1;
                    inflight_d[id_q]  = 1'b1;
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ex_req_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The CHECK stalls guarantee this clear never hits a bit being set above.
        if (w_resp_ok) begin
            pending_d[w_resp_vd]     = 1'b0;
            inflight_d[ex_resp_id_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vs3_q       <= '0;
            vd_q        <= '0;
            imm_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            op3_q       <= '0;
            pending_q   <= '0;
            inflight_q  <= '0;
            cmt_valid_q <= 1'b0;
            cmt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            vs3_q       <= vs3_d;
            vd_q        <= vd_d;
            imm_q       <= imm_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            op3_q       <= op3_d;
            pending_q   <= pending_d;
            inflight_q  <= inflight_d;
            cmt_valid_q <= w_resp_ok;
            if (w_resp_ok) begin
                cmt_id_q <= ex_resp_id_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_check_go && !rst_i) begin
            vd_tab_q[id_q] <= vd_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xadac_vrf_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_xadac_vrf_dispatch
// Description : Vector table, corner-case sequences and random traffic vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xadac_vrf_dispatch;

    localparam int unsigned NV = 32;
    localparam int unsigned VW = xadac_pkg::VectorWidth;
    localparam int          NRAND = 60;

    typedef logic [VW-1:0] vec_t;

    typedef struct {
        logic [2:0] id;
        logic [4:0] vs1, vs2, vs3, vd;
        logic [4:0] imm;
        vec_t       e1, e2, e3;
        vec_t       res;
    } vec_rec_t;

    typedef struct {
        logic [2:0] id;
        logic [4:0] vs1, vs2, vs3, vd;
        logic [4:0] imm;
    } ins_t;

    typedef struct {
        logic [2:0] id;
        logic [4:0] vd;
        vec_t       res;
        int         due;
    } out_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       dec_valid_i, dec_ready_o;
    logic [2:0] dec_id_i;
    logic [4:0] dec_vs1_i, dec_vs2_i, dec_vs3_i, dec_vd_i, dec_imm_i;
    logic       ex_req_valid_o, ex_req_ready_i;
    logic [2:0] ex_req_id_o;
    vec_t       ex_req_vs1_o, ex_req_vs2_o, ex_req_vs3_o;
    logic [4:0] ex_req_imm_o;
    logic       ex_resp_valid_i, ex_resp_ready_o;
    logic [2:0] ex_resp_id_i;
    vec_t       ex_resp_vd_i;
    logic       wr_valid_i;
    logic [4:0] wr_addr_i;
    vec_t       wr_data_i;
    logic       cmt_valid_o;
    logic [2:0] cmt_id_o;

    always #5 clk_i = ~clk_i;

    xadac_vrf_dispatch dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .dec_valid_i (dec_valid_i), .dec_ready_o (dec_ready_o), .dec_id_i (dec_id_i),
        .dec_vs1_i (dec_vs1_i), .dec_vs2_i (dec_vs2_i), .dec_vs3_i (dec_vs3_i),
        .dec_vd_i (dec_vd_i), .dec_imm_i (dec_imm_i),
        .ex_req_valid_o (ex_req_valid_o), .ex_req_ready_i (ex_req_ready_i),
        .ex_req_id_o (ex_req_id_o), .ex_req_vs1_o (ex_req_vs1_o),
        .ex_req_vs2_o (ex_req_vs2_o), .ex_req_vs3_o (ex_req_vs3_o),
        .ex_req_imm_o (ex_req_imm_o),
        .ex_resp_valid_i (ex_resp_valid_i), .ex_resp_ready_o (ex_resp_ready_o),
        .ex_resp_id_i (ex_resp_id_i), .ex_resp_vd_i (ex_resp_vd_i),
        .wr_valid_i (wr_valid_i), .wr_addr_i (wr_addr_i), .wr_data_i (wr_data_i),
        .cmt_valid_o (cmt_valid_o), .cmt_id_o (cmt_id_o)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t m_vrf [NV];

    function automatic vec_t bvec(input logic [7:0] b);
        return {(VW/8){b}};
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input vec_t act, input vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic ext_wr(input logic [4:0] a, input vec_t d);
        wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_valid_i = 1'b0;
        m_vrf[a] = d;
    endtask

    task automatic send_dec(input logic [2:0] id, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] s3, input logic [4:0] vd, input logic [4:0] imm);
        int t;
        t = 0;
        while (!dec_ready_o && t < 50) begin tick(); t++; end
        chk("dec_ready_wait", dec_ready_o, 1);
        dec_valid_i = 1'b1; dec_id_i = id; dec_vs1_i = s1; dec_vs2_i = s2;
        dec_vs3_i = s3; dec_vd_i = vd; dec_imm_i = imm;
        tick();
        dec_valid_i = 1'b0;
    endtask

    // Checks the visible request fields, then completes the handshake in this cycle.
    task automatic issue_check(input string nm, input logic [2:0] id, input logic [4:0] imm,
                               input vec_t e1, input vec_t e2, input vec_t e3);
        chk({nm, "_valid"}, ex_req_valid_o, 1);
        chk({nm, "_id"}, ex_req_id_o, id);
        chk({nm, "_imm"}, ex_req_imm_o, imm);
        chk({nm, "_vs1"}, ex_req_vs1_o, e1);
        chk({nm, "_vs2"}, ex_req_vs2_o, e2);
        chk({nm, "_vs3"}, ex_req_vs3_o, e3);
        ex_req_ready_i = 1'b1;
        tick();
        ex_req_ready_i = 1'b0;
    endtask

    task automatic respond(input logic [2:0] id, input logic [4:0] vd, input vec_t res,
                           input bit known);
        ex_resp_valid_i = 1'b1; ex_resp_id_i = id; ex_resp_vd_i = res;
        #1;
        chk("resp_ready", ex_resp_ready_o, 1);
        tick();
        ex_resp_valid_i = 1'b0;
        chk("cmt_valid", cmt_valid_o, known);
        if (known) begin
            chk("cmt_id", cmt_id_o, id);
            m_vrf[vd] = res;
        end
        tick();
        chk("cmt_pulse", cmt_valid_o, 0);
    endtask

    task automatic run_instr(input string nm, input logic [2:0] id, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [4:0] s3, input logic [4:0] vd,
                             input logic [4:0] imm, input vec_t e1, input vec_t e2,
                             input vec_t e3, input vec_t res);
        int lat;
        send_dec(id, s1, s2, s3, vd, imm);
        lat = 1;
        while (!ex_req_valid_o && lat < 50) begin tick(); lat++; end
        chk({nm, "_latency"}, lat, 2);
        issue_check(nm, id, imm, e1, e2, e3);
        chk({nm, "_dec_ready_after"}, dec_ready_o, 1);
        respond(id, vd, res, 1'b1);
    endtask

    vec_rec_t tbl [4];
    ins_t     dq [$];
    out_t     oq [$];
    ins_t     x;
    vec_t     r0, r1, w9;
    int       cyc, sent, ridx, hz;
    bit       ecv, bogus, used;
    logic [2:0] ecid, bid;

    initial begin
        rst_i = 1'b1; dec_valid_i = 0; dec_id_i = 0; dec_vs1_i = 0; dec_vs2_i = 0;
        dec_vs3_i = 0; dec_vd_i = 0; dec_imm_i = 0; ex_req_ready_i = 0;
        ex_resp_valid_i = 0; ex_resp_id_i = 0; ex_resp_vd_i = '0;
        wr_valid_i = 1'b1; wr_addr_i = 0; wr_data_i = '0;

        // ---------------- reset state
        tick(); tick();
        chk("rst_dec_ready", dec_ready_o, 0);
        chk("rst_req_valid", ex_req_valid_o, 0);
        chk("rst_cmt_valid", cmt_valid_o, 0);
        chk("rst_cmt_id", cmt_id_o, 0);
        chk("rst_req_vs1", ex_req_vs1_o, 0);
        chk("rst_req_id", ex_req_id_o, 0);
        chk("rst_resp_ready_wr", ex_resp_ready_o, 0);
        rst_i = 1'b0; wr_valid_i = 1'b0;
        #1;
        chk("post_rst_resp_ready", ex_resp_ready_o, 1);
        chk("post_rst_dec_ready", dec_ready_o, 1);

        for (int r = 0; r < NV; r++) ext_wr(5'(r), bvec((r < 16) ? 8'(r * 17) : 8'(r)));

        // ---------------- vector table
        tbl[0] = '{3'd2, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4,
                   bvec(8'h11), bvec(8'h22), bvec(8'h33), bvec(8'hAB)};
        tbl[1] = '{3'd5, 5'd4, 5'd5, 5'd1, 5'd6, 5'd31,
                   bvec(8'hAB), bvec(8'h55), bvec(8'h11), bvec(8'hCD)};
        tbl[2] = '{3'd7, 5'd6, 5'd6, 5'd4, 5'd1, 5'd0,
                   bvec(8'hCD), bvec(8'hCD), bvec(8'hAB), bvec(8'h01)};
        tbl[3] = '{3'd0, 5'd1, 5'd0, 5'd15, 5'd15, 5'd17,
                   bvec(8'h01), bvec(8'h00), bvec(8'hFF), bvec(8'hEE)};
        for (int i = 0; i < 4; i++)
            run_instr($sformatf("tbl%0d", i), tbl[i].id, tbl[i].vs1, tbl[i].vs2, tbl[i].vs3,
                      tbl[i].vd, tbl[i].imm, tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].res);

        // ---------------- RAW hazard, delayed response, held ready
        send_dec(3'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd9);
        tick();
        issue_check("raw_first", 3'd0, 5'd9, m_vrf[1], m_vrf[2], m_vrf[3]);
        send_dec(3'd1, 5'd4, 5'd2, 5'd3, 5'd8, 5'd3);
        for (int k = 0; k < 5; k++) begin
            chk("raw_stall", ex_req_valid_o, 0);
            tick();
        end
        r0 = rvec();
        respond(3'd0, 5'd4, r0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", ex_req_valid_o, 1);
            chk("hold_vs1", ex_req_vs1_o, r0);
            chk("hold_vs2", ex_req_vs2_o, m_vrf[2]);
            chk("hold_vs3", ex_req_vs3_o, m_vrf[3]);
            chk("hold_id", ex_req_id_o, 1);
            chk("hold_dec_ready", dec_ready_o, 0);
            tick();
        end
        issue_check("raw_second", 3'd1, 5'd3, r0, m_vrf[2], m_vrf[3]);

        // ---------------- external write colliding with a result
        w9 = rvec(); r1 = rvec();
        wr_valid_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = w9;
        ex_resp_valid_i = 1'b1; ex_resp_id_i = 3'd1; ex_resp_vd_i = r1;
        #1;
        chk("collide_resp_ready", ex_resp_ready_o, 0);
        tick();
        wr_valid_i = 1'b0; m_vrf[9] = w9;
        #1;
        chk("collide_retry_ready", ex_resp_ready_o, 1);
        chk("collide_no_cmt", cmt_valid_o, 0);
        tick();
        ex_resp_valid_i = 1'b0; m_vrf[8] = r1;
        chk("collide_cmt", cmt_valid_o, 1);
        chk("collide_cmt_id", cmt_id_o, 1);
        tick();
        run_instr("collide_read", 3'd4, 5'd9, 5'd8, 5'd4, 5'd10, 5'd1,
                  w9, r1, r0, rvec());

        // ---------------- in-flight ID reuse
        send_dec(3'd3, 5'd1, 5'd2, 5'd3, 5'd11, 5'd0);
        tick();
        issue_check("reuse_first", 3'd3, 5'd0, m_vrf[1], m_vrf[2], m_vrf[3]);
        send_dec(3'd3, 5'd5, 5'd6, 5'd7, 5'd12, 5'd1);
        for (int k = 0; k < 4; k++) begin
            chk("reuse_stall", ex_req_valid_o, 0);
            tick();
        end
        respond(3'd3, 5'd11, rvec(), 1'b1);
        issue_check("reuse_second", 3'd3, 5'd1, m_vrf[5], m_vrf[6], m_vrf[7]);
        respond(3'd3, 5'd12, rvec(), 1'b1);

        // ---------------- reset while in ISSUE, then a late response
        send_dec(3'd6, 5'd1, 5'd2, 5'd3, 5'd13, 5'd2);
        tick();
        chk("pre_rst_valid", ex_req_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rst_cycle_req_valid", ex_req_valid_o, 0);
        chk("rst_cycle_dec_ready", dec_ready_o, 0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("after_rst_dec_ready", dec_ready_o, 1);
        chk("after_rst_req_vs1", ex_req_vs1_o, 0);
        respond(3'd6, 5'd13, rvec(), 1'b0);
        run_instr("late_resp_read", 3'd6, 5'd13, 5'd12, 5'd11, 5'd14, 5'd5,
                  m_vrf[13], m_vrf[12], m_vrf[11], rvec());

        // ---------------- random traffic against the model
        cyc = 0; sent = 0; ecv = 0; ecid = 0;
        while ((sent < NRAND || dq.size() > 0 || oq.size() > 0) && cyc < 4000) begin
            chk("rnd_cmt_valid", cmt_valid_o, ecv);
            if (ecv) chk("rnd_cmt_id", cmt_id_o, ecid);
            ecv = 0;

            wr_valid_i = dec_ready_o && ($urandom_range(3) == 0);
            wr_addr_i  = 5'($urandom_range(7));
            wr_data_i  = rvec();
            dec_valid_i = 1'b0;
            if (dec_ready_o && sent < NRAND && $urandom_range(1) == 1) begin
                x.id = 3'($urandom_range(7)); x.vs1 = 5'($urandom_range(7));
                x.vs2 = 5'($urandom_range(7)); x.vs3 = 5'($urandom_range(7));
                x.vd = 5'($urandom_range(7)); x.imm = 5'($urandom_range(31));
                dec_valid_i = 1'b1; dec_id_i = x.id; dec_vs1_i = x.vs1; dec_vs2_i = x.vs2;
                dec_vs3_i = x.vs3; dec_vd_i = x.vd; dec_imm_i = x.imm;
                dq.push_back(x);
                sent++;
            end
            ex_req_ready_i = 1'($urandom_range(1));

            ex_resp_valid_i = 1'b0; bogus = 0; ridx = -1;
            foreach (oq[i]) if (ridx < 0 && oq[i].due <= cyc) ridx = i;
            if (ridx >= 0) begin
                ex_resp_valid_i = 1'b1; ex_resp_id_i = oq[ridx].id; ex_resp_vd_i = oq[ridx].res;
            end else if ($urandom_range(7) == 0) begin
                bid = 3'($urandom_range(7)); used = 0;
                foreach (oq[i]) if (oq[i].id == bid) used = 1;
                foreach (dq[i]) if (dq[i].id == bid) used = 1;
                if (!used) begin
                    ex_resp_valid_i = 1'b1; ex_resp_id_i = bid; ex_resp_vd_i = rvec(); bogus = 1;
                end
            end
            #1;
            chk("rnd_resp_ready", ex_resp_ready_o, !wr_valid_i);

            if (ex_req_valid_o) begin
                if (dq.size() == 0) begin
                    chk("rnd_req_unexpected", 1, 0);
                end else begin
                    x = dq[0];
                    chk("rnd_req_id", ex_req_id_o, x.id);
                    chk("rnd_req_imm", ex_req_imm_o, x.imm);
                    chk("rnd_req_vs1", ex_req_vs1_o, m_vrf[x.vs1]);
                    chk("rnd_req_vs2", ex_req_vs2_o, m_vrf[x.vs2]);
                    chk("rnd_req_vs3", ex_req_vs3_o, m_vrf[x.vs3]);
                    chk("rnd_req_dec_ready", dec_ready_o, 0);
                    hz = 0;
                    foreach (oq[i])
                        if (oq[i].id == x.id || oq[i].vd == x.vs1 || oq[i].vd == x.vs2 ||
                            oq[i].vd == x.vs3 || oq[i].vd == x.vd) hz = 1;
                    chk("rnd_hazard", hz, 0);
                    if (ex_req_ready_i) begin
                        void'(dq.pop_front());
                        oq.push_back('{x.id, x.vd, rvec(), cyc + 1 + $urandom_range(5)});
                    end
                end
            end
            if (ex_resp_valid_i && ex_resp_ready_o && !bogus) begin
                m_vrf[oq[ridx].vd] = oq[ridx].res;
                ecv = 1; ecid = oq[ridx].id;
                oq.delete(ridx);
            end
            if (wr_valid_i) m_vrf[wr_addr_i] = wr_data_i;
            tick();
            cyc++;
        end
        dec_valid_i = 0; wr_valid_i = 0; ex_resp_valid_i = 0; ex_req_ready_i = 0;
        chk("rnd_timeout", (cyc < 4000) ? 1 : 0, 1);
        chk("rnd_cmt_valid_last", cmt_valid_o, ecv);
        if (ecv) chk("rnd_cmt_id_last", cmt_id_o, ecid);
        tick();

        // Read back the randomly written registers through the dispatch path.
        run_instr("final_read_a", 3'd0, 5'd0, 5'd1, 5'd2, 5'd20, 5'd0,
                  m_vrf[0], m_vrf[1], m_vrf[2], rvec());
        run_instr("final_read_b", 3'd1, 5'd3, 5'd4, 5'd5, 5'd21, 5'd0,
                  m_vrf[3], m_vrf[4], m_vrf[5], rvec());
        run_instr("final_read_c", 3'd2, 5'd6, 5'd7, 5'd20, 5'd22, 5'd0,
                  m_vrf[6], m_vrf[7], m_vrf[20], rvec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
